// File: rtl/mips_main_fsm.sv
// mips_main_fsm
//   Moore main controller for the multicycle MIPS core. It steps through fetch, decode and
//   execute based on the instruction opcode. It drives the datapath mux selects and write
//   strobes. It also drives the ALUOp field for the ALU decoder and the PCWrite/Branch pair.
//   External logic combines that pair as PCEn = PCWrite | (Branch & zero).
//   Supported opcodes are lw, sw, R-type, beq, addi and j. Any other opcode returns to fetch
//   after decode and raises illegal_op for the decode cycle.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset; forces FETCH and masks all write strobes
//   op[5:0]    in   opcode from IR, stable from DECODE onward
//   IorD       out  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out  data memory write strobe
//   IRWrite    out  instruction register load
//   PCWrite    out  unconditional PC load
//   Branch     out  conditional PC load request
//   ALUSrcA    out  ALU A select (0 PC, 1 rs)
//   ALUSrcB    out  ALU B select (00 rt, 01 4, 10 signimm, 11 signimm<<2)
//   ALUOp      out  ALU decoder control (00 add, 01 sub, 10 funct)
//   PCSrc      out  next-PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   RegDst     out  write register select (0 rt, 1 rd)
//   MemtoReg   out  writeback select (0 ALUOut, 1 memory data)
//   RegWrite   out  register file write enable
//   state[3:0] out  current state code
//   illegal_op out  high in DECODE when op is unsupported

module mips_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_t;

    state_t state_q, state_d;

    // Strobe values before reset masking.
    logic mem_write_raw;
    logic ir_write_raw;
    logic pc_write_raw;
    logic branch_raw;
    logic reg_write_raw;

    logic op_supported;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        op_supported = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
            default:                                       op_supported = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default:      state_d = StFetch;
                endcase
            end
            // op is looked at again here to pick the load or store path.
            StMemAdr: begin
                case (op)
                    OP_LW:   state_d = StMemRd;
                    OP_SW:   state_d = StMemWr;
                    default: state_d = StFetch;
                endcase
            end
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StMemWr, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
            // Codes 12-15 have no state and go straight back to fetch.
            default:  state_d = StFetch;
        endcase
    end

    // Moore outputs. Every signal starts at 0, and each state sets only the signals it needs.
    always_comb begin
        IorD          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        branch_raw    = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSrc         = 2'b00;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        reg_write_raw = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcB      = 2'b01;
            end
            StDecode: begin
                // Precompute the branch target while the opcode is being decoded.
                ALUSrcB = 2'b11;
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: begin
                IorD = 1'b1;
            end
            StMemWb: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            StMemWr: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            StAluWb: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            StBranch: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                branch_raw = 1'b1;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StAddiWb: begin
                reg_write_raw = 1'b1;
            end
            StJump: begin
                PCSrc        = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset clears state_q asynchronously, and state_q is FETCH during reset, which would
    // raise IRWrite/PCWrite. The strobes are therefore also masked combinationally. This
    // keeps every write silent while reset is high, starting from the moment it asserts.
    assign MemWrite = mem_write_raw & ~reset;
    assign IRWrite  = ir_write_raw  & ~reset;
    assign PCWrite  = pc_write_raw  & ~reset;
    assign Branch   = branch_raw    & ~reset;
    assign RegWrite = reg_write_raw & ~reset;

    assign state      = state_q;
    assign illegal_op = (state_q == StDecode) && !op_supported;

endmodule
